dram_cmd_scheduler: RTL and testbench
=====================================

# dram_cmd_scheduler

Single-bank DRAM command scheduler between a requester and the DRAM command bus. Turns read/write requests (row, column) into legal ACT/READ/WRITE/PRE sequences and issues each command at the earliest cycle that meets tRCD, tRAS and tRP. Tracks the open row and uses an open-page policy by default. Its output is the stream our DRAM timing checker monitors.

## Interface
- `ROW_W`, 14, row address width
- `COL_W`, 10, column address width
- `TRCD`, 3, minimum cycles from ACT to READ/WRITE (≥1)
- `TRAS`, 7, minimum cycles from ACT to PRE (≥TRCD)
- `TRP`, 3, minimum cycles from PRE to ACT (≥1)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request pending; held with fields stable until accepted
- `req_write` in 1: 1 = WRITE, 0 = READ
- `req_row` in ROW_W: target row
- `req_col` in COL_W: target column
- `req_ready` out 1: combinational; high in the cycle the request is accepted
- `cmd_valid` out 1: registered; command on `cmd` this cycle
- `cmd` out 2: ACT=00, READ=01, WRITE=10, PRE=11
- `cmd_row` out ROW_W: row for ACT, otherwise the open row
- `cmd_col` out COL_W: column for READ/WRITE, otherwise 0
- `row_open` out 1: registered; a row is open
- `busy` out 1: registered; a PRE/ACT sequence is in progress

## Operation
- States:
  - CLOSED: no row open.
  - ACTIVATING: ACT issued, waiting for tRCD.
  - OPEN: row open, accesses allowed.
  - PRECHARGING: PRE issued, waiting for tRP.
- Counters:
  - `t_act` counts cycles since the last ACT on the output.
  - `t_pre` counts cycles since the last PRE on the output.
  - Both are $clog2(max+1) bits wide and saturate at TRAS and TRP respectively. They are never allowed to wrap.
- CLOSED, with `req_valid` and `t_pre`≥TRP: issue ACT with `req_row`, latch the open row, go to ACTIVATING.
- ACTIVATING: go to OPEN once `t_act` reaches TRCD. Requests are not accepted here.
- OPEN, row hit (`req_row` equals the open row) and `t_act`≥TRCD:
  - Assert `req_ready`.
  - Issue READ or WRITE with `req_col` next cycle.
  - Back-to-back hits issue one access per cycle.
- OPEN, row miss: hold `req_ready` low until `t_act`≥TRAS, then issue PRE and go to PRECHARGING.
- PRECHARGING: go to CLOSED once `t_pre` reaches TRP. The pending request then takes the CLOSED path.
- At most one command per cycle. When `cmd_valid`=0, `cmd` holds PRE encoding and is ignored.
- `busy`=1 in ACTIVATING and PRECHARGING, and in OPEN while a miss is waiting for tRAS.

## Timing
- Reset values:
  - `cmd_valid`=0, `cmd`=11, `cmd_row`=0, `cmd_col`=0.
  - `row_open`=0, `busy`=0, state CLOSED.
  - Counters saturated, so the first ACT is legal immediately.
- `req_ready` is high in decision cycle d. The matching command appears on outputs in d+1.
- Cold access: `req_valid` first high in cycle 0, ACT in cycle 1, `req_ready` in cycle TRCD, READ/WRITE in cycle 1+TRCD.
- Row hit in OPEN with timers satisfied: command in the cycle after `req_valid` rises.
- Row miss with ACT at output cycle a, request arriving in cycle r:
  - PRE at max(r+1, a+TRAS).
  - ACT at PRE+TRP.
  - READ/WRITE at ACT+TRCD.
- All timing bounds hold between `cmd_valid` cycles on the outputs. Every command is issued at exactly its earliest legal cycle, with no extra slack.
- `rst` high in any cycle has priority over all else:
  - Next cycle shows reset values.
  - No PRE is issued for the abandoned row.
  - A request in flight is dropped without `req_ready`.
- `req_valid` dropping before acceptance cancels the request. Any PRE/ACT already issued stands.

## Configuration
- `DRAM_SCHED_CLOSE_PAGE_EN` defined (closed-page policy):
  - After each READ/WRITE, if no row-hit request is pending in the following cycle, issue PRE at the earliest cycle with `t_act`≥TRAS.
  - `row_open` drops in the cycle after that PRE.
- Undefined (open-page policy): the row stays open until a row miss forces PRE.

## Test plan
- Cold READ, default params, row 5 col 9, `req_valid` in cycle 0:
  - ACT(row 5) in cycle 1, `req_ready` in cycle 3, READ(col 9) in cycle 4.
- Four consecutive hits (R,W,R,W) to the open row after tRCD: READ, WRITE, READ, WRITE on four consecutive cycles, no ACT/PRE.
- Miss to row 6 presented in the cycle after ACT(row 5) at cycle 1:
  - PRE at cycle 8, ACT(row 6) at cycle 11, READ at cycle 14.
- `rst` asserted in the cycle after ACT:
  - All outputs at reset values next cycle.
  - A new request then gets ACT one cycle after `req_valid`, with no intervening PRE.
- Random request stream, rows drawn from 0–3, 2000 cycles, with the timing checker bound: zero tRCD/tRAS/tRP/row-open/double-ACT errors.
- `DRAM_SCHED_CLOSE_PAGE_EN` defined, single READ at cycle 0:
  - PRE at cycle 8 (1+TRAS).
  - `row_open`=0 from cycle 9.
  - A second READ to the same row then needs a fresh ACT.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// Single-bank DRAM command scheduler: turns row/column requests into ACT/READ/WRITE/PRE
// at the earliest cycle meeting tRCD/tRAS/tRP. Define DRAM_SCHED_CLOSE_PAGE_EN for closed-page policy.
module dram_cmd_scheduler #(
  parameter int ROW_W = 14,
  parameter int COL_W = 10,
  parameter int TRCD  = 3,
  parameter int TRAS  = 7,
  parameter int TRP   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             req_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic             row_open,
  output logic             busy
);

  // state       | meaning
  // CLOSED      | no row open
  // ACTIVATING  | ACT issued, waiting for tRCD
  // OPEN        | row open, accesses allowed
  // PRECHARGING | PRE issued, waiting for tRP
  typedef enum logic [1:0] {CLOSED, ACTIVATING, OPEN, PRECHARGING} state_t;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam int AW = $clog2(TRAS + 1);
  localparam int PW = $clog2(TRP + 1);
  localparam logic [AW-1:0] TRAS_C = AW'(TRAS);
  localparam logic [AW-1:0] TRCD_C = AW'(TRCD);
  localparam logic [PW-1:0] TRP_C  = PW'(TRP);

`ifdef DRAM_SCHED_CLOSE_PAGE_EN
  localparam logic CLOSE_PAGE = 1'b1;
`else
  localparam logic CLOSE_PAGE = 1'b0;
`endif

  state_t           st, st_eff;
  logic [ROW_W-1:0] open_row;
  logic [AW-1:0]    t_act;
  logic [PW-1:0]    t_pre;
  logic             close_pend;
  logic             row_hit;

  // Timers hold the gap a command issued next cycle would have, so a wait state
  // whose timer is already satisfied acts as the following state this cycle.
  always_comb begin
    st_eff = st;
    if (st == ACTIVATING && t_act >= TRCD_C)
      st_eff = OPEN;
    else if (st == PRECHARGING && t_pre >= TRP_C)
      st_eff = CLOSED;
  end

  assign row_hit   = req_valid && (req_row == open_row);
  assign req_ready = !rst && (st_eff == OPEN) && row_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= CLOSED;
      open_row   <= '0;
      t_act      <= TRAS_C;
      t_pre      <= TRP_C;
      close_pend <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd        <= CMD_PRE;
      cmd_row    <= '0;
      cmd_col    <= '0;
      row_open   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_PRE;
      cmd_row   <= open_row;
      cmd_col   <= '0;
      if (t_act < TRAS_C) t_act <= t_act + 1'b1;
      if (t_pre < TRP_C)  t_pre <= t_pre + 1'b1;

      case (st_eff)
        CLOSED: begin
          if (req_valid && t_pre >= TRP_C) begin
            cmd_valid <= 1'b1;
            cmd       <= CMD_ACT;
            cmd_row   <= req_row;
            open_row  <= req_row;
            t_act     <= AW'(1);
            st        <= ACTIVATING;
            row_open  <= 1'b1;
            busy      <= 1'b1;
          end else begin
            st       <= CLOSED;
            row_open <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ACTIVATING: begin
          st   <= ACTIVATING;
          busy <= 1'b1;
        end
        OPEN: begin
          if (row_hit) begin
            cmd_valid  <= 1'b1;
            cmd        <= req_write ? CMD_WR : CMD_RD;
            cmd_col    <= req_col;
            close_pend <= CLOSE_PAGE;
            st         <= OPEN;
            busy       <= 1'b0;
          end else if ((req_valid || close_pend) && t_act >= TRAS_C) begin
            // row_open stays high through the PRE cycle and drops after it
            cmd_valid  <= 1'b1;
            cmd        <= CMD_PRE;
            t_pre      <= PW'(1);
            close_pend <= 1'b0;
            st         <= PRECHARGING;
            busy       <= 1'b1;
          end else begin
            st   <= OPEN;
            busy <= req_valid;
          end
        end
        PRECHARGING: begin
          st       <= PRECHARGING;
          row_open <= 1'b0;
          busy     <= 1'b1;
        end
        default: st <= CLOSED;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: timestamp-based reference model, directed scenarios,
// a random request stream and an output timing checker.
module tb_dram_cmd_scheduler;
  localparam int ROW_W = 14;
  localparam int COL_W = 10;
  localparam int TRCD  = 3;
  localparam int TRAS  = 7;
  localparam int TRP   = 3;

`ifdef DRAM_SCHED_CLOSE_PAGE_EN
  localparam bit CLOSE_PAGE = 1'b1;
`else
  localparam bit CLOSE_PAGE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_write;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             req_ready, cmd_valid, row_open, busy;
  logic [1:0]       cmd;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;

  always #5 clk = ~clk;

  dram_cmd_scheduler #(.ROW_W(ROW_W), .COL_W(COL_W), .TRCD(TRCD), .TRAS(TRAS), .TRP(TRP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_row(req_row), .req_col(req_col), .req_ready(req_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .row_open(row_open), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int               c;
    logic [1:0]       cmd;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } ev_t;
  ev_t ev[$];
  bit  ro_at[int];
  bit  dut_ready;

  // reference model: open row plus output-cycle timestamps of the last ACT and PRE
  bit               m_open, m_pend, m_ready;
  logic [ROW_W-1:0] m_row;
  int               m_last_act, m_last_pre;
  bit               e_valid, e_ro;
  logic [1:0]       e_cmd;
  logic [ROW_W-1:0] e_row;
  logic [COL_W-1:0] e_col;

  // independent output timing checker
  bit k_open;
  int k_act, k_pre;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_open = 0; m_pend = 0; m_ready = 0; m_row = '0;
    m_last_act = -1000; m_last_pre = -1000;
    e_valid = 0; e_cmd = 2'b11; e_row = '0; e_col = '0; e_ro = 0;
  endfunction

  function automatic void model_step(bit r, bit v, bit w, logic [ROW_W-1:0] row, logic [COL_W-1:0] col);
    int n = cyc + 1;
    e_valid = 0; e_cmd = 2'b11; e_col = '0; m_ready = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (!m_open) begin
      if (v && n - m_last_pre >= TRP) begin
        e_valid = 1; e_cmd = 2'b00; m_row = row; m_open = 1; m_last_act = n;
      end
    end else if (n - m_last_act >= TRCD) begin
      if (v && row == m_row) begin
        m_ready = 1; e_valid = 1; e_cmd = w ? 2'b10 : 2'b01; e_col = col; m_pend = CLOSE_PAGE;
      end else if ((v || m_pend) && n - m_last_act >= TRAS) begin
        e_valid = 1; e_cmd = 2'b11; m_last_pre = n; m_open = 0; m_pend = 0;
      end
    end
    e_row = m_row;
    e_ro  = m_open || (m_last_pre == n);
  endfunction

  task automatic timing_check();
    case (cmd)
      2'b00: begin
        chk("tRP", (cyc - k_pre >= TRP), 1);
        chk("double_act", k_open, 0);
        k_open = 1; k_act = cyc;
      end
      2'b11: begin
        chk("tRAS", (cyc - k_act >= TRAS), 1);
        chk("pre_closed", k_open, 1);
        k_open = 0; k_pre = cyc;
      end
      default: begin
        chk("tRCD", (cyc - k_act >= TRCD), 1);
        chk("access_closed", k_open, 1);
      end
    endcase
  endtask

  task automatic tick(input bit r, input bit v, input bit w,
                      input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    chk("cmd_valid", cmd_valid, e_valid);
    chk("cmd", cmd, e_cmd);
    chk("cmd_row", cmd_row, e_row);
    chk("cmd_col", cmd_col, e_col);
    chk("row_open", row_open, e_ro);
    ro_at[cyc] = row_open;
    if (cmd_valid) begin
      ev.push_back('{cyc, cmd, cmd_row, cmd_col});
      timing_check();
    end
    rst = r; req_valid = v; req_write = w; req_row = row; req_col = col;
    #1;
    model_step(r, v, w, row, col);
    chk("req_ready", req_ready, m_ready);
    dut_ready = req_ready;
    if (r) begin
      k_open = 0; k_act = -1000; k_pre = -1000;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, '0, '0);
  endtask

  task automatic issue(input bit w, input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                       output int acc_c);
    int k = 0;
    do begin
      tick(0, 1, w, row, col);
      k++;
    end while (!dut_ready && k < 40);
    chk("issue_accepted", dut_ready, 1);
    acc_c = cyc - 1;
  endtask

  function automatic ev_t get_ev(int i);
    ev_t e = '{-1, 2'b11, '0, '0};
    if (i < ev.size()) e = ev[i];
    return e;
  endfunction

  task automatic chk_ev(input string tag, input int i, input int c, input logic [1:0] ec,
                        input logic [ROW_W-1:0] row);
    ev_t e = get_ev(i);
    chk({tag, "_cycle"}, e.c, c);
    chk({tag, "_cmd"}, e.cmd, ec);
    chk({tag, "_row"}, e.row, row);
  endtask

  int t0, t1, acc;
  bit pend, pw;
  logic [ROW_W-1:0] prow;
  logic [COL_W-1:0] pcol;
  bit rr;

  initial begin
    rst = 1; req_valid = 0; req_write = 0; req_row = '0; req_col = '0;
    k_open = 0; k_act = -1000; k_pre = -1000; dut_ready = 0;
    @(posedge clk);
    #1;
    model_reset();

    // cold READ row 5 col 9
    tick(1, 0, 0, '0, '0);
    ev.delete(); t0 = cyc;
    issue(0, 5, 9, acc);
    chk("cold_ready_cycle", acc, t0 + 3);
    idle(2);
    chk_ev("cold_act", 0, t0 + 1, 2'b00, 5);
    chk_ev("cold_rd", 1, t0 + 4, 2'b01, 5);
    chk("cold_col", get_ev(1).col, 9);

    // back-to-back hits R,W,R,W
    tick(1, 0, 0, '0, '0);
    issue(0, 5, 1, acc);
    ev.delete(); t0 = cyc;
    issue(0, 5, 2, acc);
    issue(1, 5, 3, acc);
    issue(0, 5, 4, acc);
    issue(1, 5, 5, acc);
    idle(2);
    chk_ev("hit0", 1, t0 + 1, 2'b01, 5);
    chk_ev("hit1", 2, t0 + 2, 2'b10, 5);
    chk_ev("hit2", 3, t0 + 3, 2'b01, 5);
    chk_ev("hit3", 4, t0 + 4, 2'b10, 5);
    chk("hit3_col", get_ev(4).col, 5);

    // miss to row 6 presented in the cycle after ACT(row 5)
    tick(1, 0, 0, '0, '0);
    ev.delete(); t0 = cyc;
    tick(0, 1, 0, 5, 0);
    tick(0, 0, 0, '0, '0);
    issue(0, 6, 7, acc);
    idle(3);
    chk_ev("miss_act5", 0, t0 + 1, 2'b00, 5);
    chk_ev("miss_pre", 1, t0 + 8, 2'b11, 5);
    chk_ev("miss_act6", 2, t0 + 11, 2'b00, 6);
    chk_ev("miss_rd", 3, t0 + 14, 2'b01, 6);
    chk("miss_col", get_ev(3).col, 7);

    // reset in the cycle after ACT
    tick(1, 0, 0, '0, '0);
    ev.delete(); t0 = cyc;
    tick(0, 1, 0, 7, 0);
    tick(0, 1, 0, 7, 0);
    tick(1, 1, 0, 7, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 2'b11);
    chk("rst_cmd_row", cmd_row, 0);
    chk("rst_cmd_col", cmd_col, 0);
    chk("rst_row_open", row_open, 0);
    chk("rst_busy", busy, 0);
    chk_ev("rst_act", 0, t0 + 1, 2'b00, 7);
    chk("rst_act_count", ev.size(), 1);
    ev.delete(); t1 = cyc;
    issue(0, 9, 1, acc);
    idle(1);
    chk_ev("post_rst_act", 0, t1 + 1, 2'b00, 9);
    chk_ev("post_rst_rd", 1, t1 + 1 + TRCD, 2'b01, 9);

    // page policy after a single READ
    tick(1, 0, 0, '0, '0);
    ev.delete(); t0 = cyc;
    issue(0, 5, 9, acc);
    idle(8);
    t1 = cyc;
    issue(0, 5, 9, acc);
    idle(4);
`ifdef DRAM_SCHED_CLOSE_PAGE_EN
    chk_ev("cp_pre", 2, t0 + 8, 2'b11, 5);
    chk("cp_ro_pre_cycle", ro_at[t0 + 8], 1);
    chk("cp_ro_after", ro_at[t0 + 9], 0);
    chk_ev("cp_react", 3, t1 + 1, 2'b00, 5);
    chk_ev("cp_rd2", 4, t1 + 1 + TRCD, 2'b01, 5);
`else
    chk("op_ro_stays", ro_at[t0 + 9], 1);
    chk_ev("op_rd2", 2, t1 + 1, 2'b01, 5);
    chk("op_no_extra", ev.size(), 3);
`endif

    // random request stream, rows 0-3, occasional cancel and reset
    tick(1, 0, 0, '0, '0);
    pend = 0; pw = 0; prow = '0; pcol = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend) begin
        if ($urandom_range(3) != 0) begin
          pend = 1;
          pw   = 1'($urandom_range(1));
          prow = ROW_W'($urandom_range(3));
          pcol = COL_W'($urandom);
        end
      end else if ($urandom_range(31) == 0) begin
        pend = 0;
      end
      rr = ($urandom_range(499) == 0);
      tick(rr, pend, pw, prow, pcol);
      if (dut_ready || rr) pend = 0;
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
